// File: rtl/time_mux_7seg_pkg.sv
// ============================================================================
// Module   : time_mux_7seg_pkg
// Purpose  : Segment glyph constants and digit count for the 7-seg scan driver
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package time_mux_7seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  // Bit order is {g,f,e,d,c,b,a}; 1 = segment lit
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
// Module   : seg7_decoder
// Purpose  : Combinational nibble-to-segment decoder; hex glyphs for A-F only
//            when TIME_MUX_7SEG_HEX_EN is defined, otherwise A-F are blank
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_decoder
  import time_mux_7seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
`ifdef TIME_MUX_7SEG_HEX_EN
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
`else
      default: seg = SEG_BLANK;
`endif
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/time_mux_7seg_driver.sv
// ============================================================================
// Module   : time_mux_7seg_driver
// Purpose  : Time-multiplexed 4-digit 7-segment driver with per-slot blanking;
//            optional hex glyphs via TIME_MUX_7SEG_HEX_EN
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module time_mux_7seg_driver
  import time_mux_7seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 64,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_bcd,
  output logic [6:0]  seg,
  output logic [3:0]  digit_enable
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg;
  logic             w_slot_end;
  logic             w_blank;

  assign w_slot_end = (r_cnt == CNT_W'(DIGIT_CYCLES - 1));
  assign w_blank    = ({1'b0, r_cnt} < (CNT_W + 1)'(BLANK_CYCLES));
  assign w_nibble   = 4'(digits_bcd >> {r_idx, 2'b00});

  seg7_decoder u_decoder (
    .nibble (w_nibble),
    .seg    (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Outputs use the pre-update counters so the blank gap leads each slot
  always_ff @(posedge clk) begin
    if (rst || w_blank) begin
      seg          <= SEG_BLANK;
      digit_enable <= 4'h0;
    end else begin
      seg          <= w_seg;
      digit_enable <= 4'b0001 << r_idx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_time_mux_7seg_driver.sv
// ============================================================================
// Module   : tb_time_mux_7seg_driver
// Purpose  : Scoreboard bench for the time-multiplexed 7-segment driver
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_time_mux_7seg_driver;

  localparam int DC = 64;
  localparam int BC = 2;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] en;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_bcd = 16'h1234;
  logic [6:0]  seg;
  logic [3:0]  digit_enable;

  int tests  = 0;
  int fails  = 0;
  int edge_n = 0;
  int unsigned lit_edges = 0;
  exp_t q[$];

  time_mux_7seg_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk          (clk),
    .rst          (rst),
    .digits_bcd   (digits_bcd),
    .seg          (seg),
    .digit_enable (digit_enable)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef TIME_MUX_7SEG_HEX_EN
    return tbl[n];
`else
    return (n > 4'd9) ? 7'h00 : tbl[n];
`endif
  endfunction

  // Reference: position within the scan follows from edges since reset release
  task automatic step(input logic r, input logic [15:0] d);
    exp_t e;
    int   pos;
    int   slot;
    @(negedge clk);
    rst        = r;
    digits_bcd = d;
    if (r) begin
      e = '0;
      lit_edges = 0;
    end else begin
      pos  = int'(lit_edges % DC);
      slot = int'((lit_edges / DC) % 4);
      if (pos < BC) e = '0;
      else begin
        e.en  = 4'(1 << slot);
        e.seg = glyph(4'(d >> (slot * 4)));
      end
      lit_edges++;
    end
    q.push_back(e);
  endtask

  always begin
    exp_t x;
    @(posedge clk);
    #1;
    edge_n++;
    if (q.size() > 0) begin
      x = q.pop_front();
      tests++;
      if (seg !== x.seg || digit_enable !== x.en || $countones(digit_enable) > 1) begin
        fails++;
        $display("FAIL scan edge=%0d seg=%h exp=%h en=%b exp=%b", edge_n, seg, x.seg,
                 digit_enable, x.en);
      end
    end
  end

  initial begin
    logic [15:0] d;
    int guard;
    // reset for 3 cycles with 1234
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1234);
    // two full scans of 1234
    for (int i = 0; i < 512; i++) step(1'b0, 16'h1234);
    // live update while digit 0 is lit
    for (int i = 0; i < 30; i++) step(1'b0, 16'h1234);
    for (int i = 0; i < 300; i++) step(1'b0, 16'h5678);
    // all nines
    for (int i = 0; i < 1000; i++) step(1'b0, 16'h9999);
    // hex nibbles
    for (int i = 0; i < 300; i++) step(1'b0, 16'hABCD);
    // random values, changing at random moments
    d = 16'($urandom);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 15) == 0) d = 16'($urandom);
      step(1'b0, d);
    end
    // run into the middle of a digit 2 slot, then reset there
    guard = 0;
    while (!(((lit_edges / DC) % 4) == 2 && (lit_edges % DC) == 20) && guard < 1024) begin
      step(1'b0, d);
      guard++;
    end
    tests++;
    if (guard >= 1024) begin
      fails++;
      $display("FAIL midscan_seek guard=%0d limit=%0d", guard, 1024);
    end
    step(1'b1, d);
    step(1'b1, d);
    for (int i = 0; i < 300; i++) step(1'b0, 16'h4321);
    @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d exp=%0d", q.size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
